// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Purpose : Bundles the two requester ports (p0 = instruction fetch,
//           p1 = data), the memory-side request/response bus and the orphan
//           status flag used by mem_arbiter.
// Signals :
//   p0_/p1_command  [1:0]  BUS_NONE / BUS_LOAD / BUS_STORE request
//   p0_/p1_addr     [31:0] byte address
//   p0_/p1_wdata    [31:0] store data
//   p0_/p1_response [3:0]  tag accepted this cycle, 0 = not accepted
//   p0_/p1_rdata    [31:0] returning load data
//   p0_/p1_tag      [3:0]  tag of returning load, 0 = none
//   proc2mem_command/addr/data   request forwarded to memory
//   mem2proc_response/data/tag   memory accept tag, return data, return tag
//   orphan_err                   sticky: a returned tag had no owner
// Modports:
//   slave  - the arbiter (serves requesters, drives memory request)
//   master - the environment (requesters plus memory model)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  logic [1:0]  p0_command;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [3:0]  p0_response;
  logic [31:0] p0_rdata;
  logic [3:0]  p0_tag;

  logic [1:0]  p1_command;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [3:0]  p1_response;
  logic [31:0] p1_rdata;
  logic [3:0]  p1_tag;

  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [31:0] proc2mem_data;

  logic [3:0]  mem2proc_response;
  logic [31:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  logic        orphan_err;

  modport slave (
    input  p0_command, p0_addr, p0_wdata,
    input  p1_command, p1_addr, p1_wdata,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output p0_response, p0_rdata, p0_tag,
    output p1_response, p1_rdata, p1_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output orphan_err
  );

  modport master (
    output p0_command, p0_addr, p0_wdata,
    output p1_command, p1_addr, p1_wdata,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  p0_response, p0_rdata, p0_tag,
    input  p1_response, p1_rdata, p1_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  orphan_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Purpose : Two-port (fetch / data) arbiter in front of a tagged memory.
//           Grants one eligible requester per cycle combinationally, tracks
//           which port owns each outstanding load tag, routes returning load
//           data to its owner and flags returns whose tag has no owner.
// Parameters:
//   NUM_TAGS - number of memory tags (1..NUM_TAGS valid, 0 = none)
//   MAX_OUT  - maximum outstanding loads per port
// Ports:
//   clk   - single clock, all state on posedge
//   reset - asynchronous active-high reset; all outputs forced to 0 while high
//   bus   - mem_arbiter_if.slave (requester ports, memory bus, orphan_err)
// Configuration:
//   MEM_ARB_RR_EN defined   -> round-robin between ports when both eligible
//   MEM_ARB_RR_EN undefined -> fixed priority, p1 wins when both eligible
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NUM_TAGS = 15,
  parameter int MAX_OUT  = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int               CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  // Per-port views so the two requesters can be handled by one generate loop.
  logic [1:0]       cmd     [2];
  logic [31:0]      addr    [2];
  logic [31:0]      wdata   [2];
  logic [CNT_W-1:0] out_cnt [2];

  assign cmd[0]   = bus.p0_command;
  assign cmd[1]   = bus.p1_command;
  assign addr[0]  = bus.p0_addr;
  assign addr[1]  = bus.p1_addr;
  assign wdata[0] = bus.p0_wdata;
  assign wdata[1] = bus.p1_wdata;

  // ---------------------------------------------------------------------------
  // Eligibility and grant
  // ---------------------------------------------------------------------------
  logic [1:0] elig;
  logic       grant_any;
  logic       grant_sel;   // 0 = p0, 1 = p1 (meaningful only when grant_any)
  logic       accept;
  logic       load_set;
  logic [3:0] set_tag;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      // Stores are never throttled; loads stop once the port is at MAX_OUT.
      assign elig[gi] = (cmd[gi] != BUS_NONE) &&
                        ((cmd[gi] == BUS_STORE) || (out_cnt[gi] < MAX_CNT));
    end
  endgenerate

  assign grant_any = |elig;
  assign accept    = grant_any && (bus.mem2proc_response != 4'd0);
  assign set_tag   = bus.mem2proc_response;
  assign load_set  = accept && (cmd[grant_sel] == BUS_LOAD);

`ifdef MEM_ARB_RR_EN
  logic prio_reg;
  logic prio_next;

  assign grant_sel = (&elig) ? prio_reg : elig[1];

  // The pointer only moves on a contested grant that memory actually took.
  // A refusal leaves it alone, so the same port keeps retrying until served.
  always_comb begin
    prio_next = prio_reg;
    if (accept && (&elig)) begin
      prio_next = ~grant_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_reg <= 1'b0;
    end else begin
      prio_reg <= prio_next;
    end
  end
`else
  // Fixed priority: p1 whenever it is eligible, otherwise p0.
  assign grant_sel = elig[1];
`endif

  // ---------------------------------------------------------------------------
  // Tag ownership table. The vectors span the full 4-bit tag space; entries
  // outside 1..NUM_TAGS are tied off so such returns read as orphans.
  // ---------------------------------------------------------------------------
  logic [15:0] valid_vec;
  logic [15:0] owner_vec;
  logic [3:0]  ret_tag;
  logic        ret_hit;
  logic        ret_owner;
  logic        orphan;

  assign ret_tag   = bus.mem2proc_tag;
  assign ret_hit   = valid_vec[ret_tag];   // valid_vec[0] is always 0
  assign ret_owner = owner_vec[ret_tag];
  assign orphan    = (ret_tag != 4'd0) && !ret_hit;

  generate
    for (gi = 0; gi < 16; gi++) begin : g_tag
      if ((gi >= 1) && (gi <= NUM_TAGS)) begin : g_live
        logic valid_reg, valid_next;
        logic owner_reg, owner_next;

        // Set wins over clear so a tag returned and re-issued in the same
        // cycle stays valid under its new owner.
        always_comb begin
          valid_next = valid_reg;
          owner_next = owner_reg;
          if (ret_hit && (ret_tag == 4'(gi))) begin
            valid_next = 1'b0;
          end
          if (load_set && (set_tag == 4'(gi))) begin
            valid_next = 1'b1;
            owner_next = grant_sel;
          end
        end

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            valid_reg <= 1'b0;
            owner_reg <= 1'b0;
          end else begin
            valid_reg <= valid_next;
            owner_reg <= owner_next;
          end
        end

        assign valid_vec[gi] = valid_reg;
        assign owner_vec[gi] = owner_reg;
      end else begin : g_none
        assign valid_vec[gi] = 1'b0;
        assign owner_vec[gi] = 1'b0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outstanding-load counters, one per port
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic             inc;
      logic             dec;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      assign inc = load_set && (grant_sel == 1'(gi));
      assign dec = ret_hit && (ret_owner == 1'(gi));

      always_comb begin
        cnt_next = cnt_reg;
        if (inc && !dec) begin
          cnt_next = cnt_reg + 1'b1;
        end else if (dec && !inc) begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign out_cnt[gi] = cnt_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sticky orphan flag
  // ---------------------------------------------------------------------------
  logic orphan_reg;
  logic orphan_next;

  always_comb begin
    orphan_next = orphan_reg;
    if (orphan) begin
      orphan_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      orphan_reg <= 1'b0;
    end else begin
      orphan_reg <= orphan_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Everything is qualified with run so the block is silent for the
  // whole time reset is high, not just after the next clock edge.
  // ---------------------------------------------------------------------------
  logic run;
  logic drive_mem;
  assign run       = ~reset;
  assign drive_mem = run && grant_any;

  assign bus.proc2mem_command = drive_mem ? cmd[grant_sel]   : BUS_NONE;
  assign bus.proc2mem_addr    = drive_mem ? addr[grant_sel]  : 32'd0;
  assign bus.proc2mem_data    = drive_mem ? wdata[grant_sel] : 32'd0;

  // Memory's accept tag goes only to the granted port; the loser sees 0 and
  // simply retries.
  assign bus.p0_response = (drive_mem && !grant_sel) ? bus.mem2proc_response : 4'd0;
  assign bus.p1_response = (drive_mem &&  grant_sel) ? bus.mem2proc_response : 4'd0;

  assign bus.p0_tag   = (run && ret_hit && !ret_owner) ? ret_tag           : 4'd0;
  assign bus.p0_rdata = (run && ret_hit && !ret_owner) ? bus.mem2proc_data : 32'd0;
  assign bus.p1_tag   = (run && ret_hit &&  ret_owner) ? ret_tag           : 4'd0;
  assign bus.p1_rdata = (run && ret_hit &&  ret_owner) ? bus.mem2proc_data : 32'd0;

  assign bus.orphan_err = run && orphan_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios followed by a randomized run, every cycle compared with a
// tag-table reference model (owner per tag, load count per port, priority).
// Builds with or without MEM_ARB_RR_EN; expectations follow the same macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int NT = 15;
  localparam int MO = 8;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.NUM_TAGS(NT), .MAX_OUT(MO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: which port owns each tag (-1 = free), loads per port.
  int owner_m [16];
  int cnt_m   [2];
  int prio_m;
  bit orphan_m;

  int checks = 0;
  int errors = 0;

  // Last observed outputs, for directed constant checks.
  logic [1:0]  o_cmd;
  logic [31:0] o_addr, o_data, o_d0, o_d1;
  logic [3:0]  o_r0, o_r1, o_t0, o_t1;
  logic        o_orph;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) owner_m[i] = -1;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    prio_m   = 0;
    orphan_m = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.p0_command = 2'd0; bus.p0_addr = 32'd0; bus.p0_wdata = 32'd0;
    bus.p1_command = 2'd0; bus.p1_addr = 32'd0; bus.p1_wdata = 32'd0;
    bus.mem2proc_response = 4'd0; bus.mem2proc_tag = 4'd0; bus.mem2proc_data = 32'd0;
  endtask

  task automatic sample();
    o_cmd = bus.proc2mem_command; o_addr = bus.proc2mem_addr; o_data = bus.proc2mem_data;
    o_r0 = bus.p0_response; o_r1 = bus.p1_response;
    o_t0 = bus.p0_tag; o_t1 = bus.p1_tag;
    o_d0 = bus.p0_rdata; o_d1 = bus.p1_rdata;
    o_orph = bus.orphan_err;
  endtask

  // Reset asserted mid-cycle (no clock edge involved) with busy inputs;
  // outputs must already be zero 1 ns later and stay zero while held.
  task automatic do_reset(input int cyc_n);
    bus.p0_command = 2'd1; bus.p0_addr = 32'h0000_0400; bus.p0_wdata = 32'h1;
    bus.p1_command = 2'd2; bus.p1_addr = 32'h0000_0800; bus.p1_wdata = 32'h2;
    bus.mem2proc_response = 4'd6; bus.mem2proc_tag = 4'd1; bus.mem2proc_data = 32'hFFFF_0001;
    #1;
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < cyc_n; k++) begin
      #1;
      sample();
      chk("rst.cmd", 32'(o_cmd), 32'd0);
      chk("rst.addr", o_addr, 32'd0);
      chk("rst.data", o_data, 32'd0);
      chk("rst.resp0", 32'(o_r0), 32'd0);
      chk("rst.resp1", 32'(o_r1), 32'd0);
      chk("rst.tag0", 32'(o_t0), 32'd0);
      chk("rst.tag1", 32'(o_t1), 32'd0);
      chk("rst.rdata0", o_d0, 32'd0);
      chk("rst.rdata1", o_d1, 32'd0);
      chk("rst.orphan", 32'(o_orph), 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  // One clock cycle: drive, compute expectations from the model, compare at
  // the negedge, then advance the model at the posedge.
  task automatic cyc(input string nm, input logic [1:0] c0, input logic [1:0] c1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [3:0] rsp, input logic [3:0] rtag, input logic [31:0] rdat);
    int el0, el1, w, own;
    logic [1:0]  ec;
    logic [31:0] ea, ed, w0, w1;
    w0 = a0 ^ 32'hA5A5_0000;
    w1 = a1 ^ 32'h5A5A_0000;
    bus.p0_command = c0; bus.p0_addr = a0; bus.p0_wdata = w0;
    bus.p1_command = c1; bus.p1_addr = a1; bus.p1_wdata = w1;
    bus.mem2proc_response = rsp; bus.mem2proc_tag = rtag; bus.mem2proc_data = rdat;

    el0 = ((c0 != 2'd0) && ((c0 == 2'd2) || (cnt_m[0] < MO))) ? 1 : 0;
    el1 = ((c1 != 2'd0) && ((c1 == 2'd2) || (cnt_m[1] < MO))) ? 1 : 0;
    w = -1;
    if (el0 == 1 && el1 == 1) w = RR ? prio_m : 1;
    else if (el0 == 1)        w = 0;
    else if (el1 == 1)        w = 1;
    ec = (w == 0) ? c0 : (w == 1) ? c1 : 2'd0;
    ea = (w == 0) ? a0 : (w == 1) ? a1 : 32'd0;
    ed = (w == 0) ? w0 : (w == 1) ? w1 : 32'd0;
    own = (rtag != 4'd0) ? owner_m[rtag] : -1;

    #4;
    sample();
    chk({nm, ".cmd"},    32'(o_cmd), 32'(ec));
    chk({nm, ".addr"},   o_addr, ea);
    chk({nm, ".data"},   o_data, ed);
    chk({nm, ".resp0"},  32'(o_r0), (w == 0) ? 32'(rsp) : 32'd0);
    chk({nm, ".resp1"},  32'(o_r1), (w == 1) ? 32'(rsp) : 32'd0);
    chk({nm, ".tag0"},   32'(o_t0), (own == 0) ? 32'(rtag) : 32'd0);
    chk({nm, ".tag1"},   32'(o_t1), (own == 1) ? 32'(rtag) : 32'd0);
    chk({nm, ".rdata0"}, o_d0, (own == 0) ? rdat : 32'd0);
    chk({nm, ".rdata1"}, o_d1, (own == 1) ? rdat : 32'd0);
    chk({nm, ".orphan"}, 32'(o_orph), 32'(orphan_m));

    @(posedge clk);
    if (own >= 0) begin
      cnt_m[own]--;
      owner_m[rtag] = -1;
    end else if (rtag != 4'd0) begin
      orphan_m = 1'b1;
    end
    if (w >= 0 && rsp != 4'd0) begin
      if (ec == 2'd1) begin
        owner_m[rsp] = w;
        cnt_m[w]++;
      end
      if (el0 == 1 && el1 == 1) prio_m = 1 - w;
    end
    #1;
  endtask

  int          fq[$];
  int          vq[$];
  logic [1:0]  rc0, rc1;
  logic [3:0]  rrsp, rrt;
  int          rsel;

  initial begin
    reset = 1'b1;
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    do_reset(2);

    // p0 load accepted as tag 3, later returned with data.
    cyc("r28.issue", 2'd1, 2'd0, 32'h100, 32'h0, 4'd3, 4'd0, 32'h0);
    chk("r28.resp0", 32'(o_r0), 32'd3);
    chk("r28.resp1", 32'(o_r1), 32'd0);
    cyc("r28.wait", 2'd0, 2'd0, 32'h0, 32'h0, 4'd0, 4'd0, 32'h0);
    cyc("r28.ret", 2'd0, 2'd0, 32'h0, 32'h0, 4'd0, 4'd3, 32'hDEADBEEF);
    chk("r28.tag0", 32'(o_t0), 32'd3);
    chk("r28.rdata0", o_d0, 32'hDEADBEEF);
    chk("r28.tag1", 32'(o_t1), 32'd0);

    // Both ports load every cycle, memory always accepts.
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      cyc("r29.both", 2'd1, 2'd1, 32'h1000, 32'h2000, 4'(k + 1), 4'd0, 32'h0);
      chk("r29.winner", o_addr, RR ? ((k % 2 == 0) ? 32'h1000 : 32'h2000) : 32'h2000);
    end
    for (int k = 1; k <= 4; k++)
      cyc("r29.drain", 2'd0, 2'd0, 32'h0, 32'h0, 4'd0, 4'(k), 32'h7000_0000 + 32'(k));

    // One accepted contest leaves prio at p1 (RR); then three refusals.
    cyc("r30.setup", 2'd1, 2'd1, 32'h1000, 32'h2000, 4'd5, 4'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc("r30.refuse", 2'd1, 2'd1, 32'h1000, 32'h2000, 4'd0, 4'd0, 32'h0);
      chk("r30.hold", o_addr, 32'h2000);
    end
    cyc("r30.accept", 2'd1, 2'd1, 32'h1000, 32'h2000, 4'd6, 4'd0, 32'h0);
    chk("r30.accept_p1", o_addr, 32'h2000);
    cyc("r30.next", 2'd1, 2'd1, 32'h1000, 32'h2000, 4'd7, 4'd0, 32'h0);
    chk("r30.after", o_addr, RR ? 32'h1000 : 32'h2000);

    // p1 fills its MAX_OUT budget.
    do_reset(1);
    for (int k = 0; k < MO; k++)
      cyc("r31.fill", 2'd0, 2'd1, 32'h0, 32'h2000 + 32'(4 * k), 4'(k + 1), 4'd0, 32'h0);
    cyc("r31.full", 2'd1, 2'd1, 32'h1000, 32'h2100, 4'd9, 4'd0, 32'h0);
    chk("r31.p0_wins", o_addr, 32'h1000);
    chk("r31.resp1", 32'(o_r1), 32'd0);
    cyc("r31.store", 2'd0, 2'd2, 32'h0, 32'h2200, 4'd10, 4'd0, 32'h0);
    chk("r31.store_cmd", 32'(o_cmd), 32'd2);
    cyc("r31.blocked", 2'd0, 2'd1, 32'h0, 32'h2300, 4'd11, 4'd0, 32'h0);
    chk("r31.blocked_cmd", 32'(o_cmd), 32'd0);

    // Tag 5 returned to p0 and re-issued to p1 in the same cycle; orphan tag 7.
    do_reset(1);
    cyc("r32.p0", 2'd1, 2'd0, 32'h1000, 32'h0, 4'd5, 4'd0, 32'h0);
    cyc("r32.swap", 2'd0, 2'd1, 32'h0, 32'h2000, 4'd5, 4'd5, 32'hCAFE0005);
    chk("r32.tag0", 32'(o_t0), 32'd5);
    chk("r32.rdata0", o_d0, 32'hCAFE0005);
    chk("r32.resp1", 32'(o_r1), 32'd5);
    cyc("r32.ret_p1", 2'd0, 2'd0, 32'h0, 32'h0, 4'd0, 4'd5, 32'h11110005);
    chk("r32.tag1", 32'(o_t1), 32'd5);
    chk("r32.tag0_none", 32'(o_t0), 32'd0);
    cyc("r32.orphan", 2'd0, 2'd0, 32'h0, 32'h0, 4'd0, 4'd7, 32'h77);
    cyc("r32.idle", 2'd0, 2'd0, 32'h0, 32'h0, 4'd0, 4'd0, 32'h0);
    chk("r32.sticky", 32'(o_orph), 32'd1);
    cyc("r32.idle2", 2'd1, 2'd0, 32'h3000, 32'h0, 4'd0, 4'd0, 32'h0);
    chk("r32.sticky2", 32'(o_orph), 32'd1);

    // Four loads outstanding, reset mid-cycle, pre-reset tag returns as orphan.
    for (int k = 1; k <= 4; k++)
      cyc("r33.load", (k % 2 == 1) ? 2'd1 : 2'd0, (k % 2 == 0) ? 2'd1 : 2'd0,
          32'h4000, 32'h5000, 4'(k), 4'd0, 32'h0);
    do_reset(2);
    cyc("r33.stale", 2'd0, 2'd0, 32'h0, 32'h0, 4'd0, 4'd2, 32'h2222);
    chk("r33.stale_tag0", 32'(o_t0), 32'd0);
    cyc("r33.idle", 2'd0, 2'd0, 32'h0, 32'h0, 4'd0, 4'd0, 32'h0);
    chk("r33.orphan", 32'(o_orph), 32'd1);

    // Randomized traffic against the model.
    do_reset(1);
    for (int n = 0; n < 400; n++) begin
      fq.delete();
      vq.delete();
      for (int t = 1; t <= NT; t++) begin
        if (owner_m[t] < 0) fq.push_back(t);
        else                vq.push_back(t);
      end
      rc0 = 2'($urandom_range(0, 2));
      rc1 = 2'($urandom_range(0, 2));
      rrsp = 4'd0;
      if (fq.size() > 0 && $urandom_range(0, 3) != 0)
        rrsp = 4'(fq[$urandom_range(0, fq.size() - 1)]);
      rrt  = 4'd0;
      rsel = int'($urandom_range(0, 29));
      if (rsel < 12 && vq.size() > 0) rrt = 4'(vq[$urandom_range(0, vq.size() - 1)]);
      else if (rsel == 29)            rrt = 4'($urandom_range(1, 15));
      cyc("rand", rc0, rc1, $urandom, $urandom, rrsp, rrt, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
